// File: rtl/char_motion_ctrl.sv
// ---------------------------------------------------------------------------
// char_motion_ctrl
//
// Owns the character overlay's display window. Once per frame it steps the
// window by speedH/speedV, bounces it off the usable-area limits, and commits
// all four window edges together so the renderer never sees a torn window.
// A load strobe can place the window anywhere (clamped to the legal range).
//
// Optional feature macro: CHAR_FLASH_EN
//   defined   : a frame counter drives flashClk, toggling every FLASH_FRAMES
//               frame ticks.
//   undefined : no flash counter exists and flashClk is tied to 0.
//
// Ports
//   clock        in   pixel clock
//   reset        in   synchronous, active-high reset
//   frameTick    in   one-cycle strobe per frame (vertical blanking)
//   enable       in   motion enable
//   speedH       in   [3:0] horizontal step, pixels per frame
//   speedV       in   [3:0] vertical step, lines per frame
//   loadEn       in   one-cycle strobe: load loadH/loadV as the new position
//   loadH/loadV  in   [8:0] position to load
//   posHorStart  out  [8:0] window horizontal start
//   posHorEnd    out  [8:0] posHorStart + CHAR_W
//   posVerStart  out  [8:0] window vertical start
//   posVerEnd    out  [8:0] posVerStart + CHAR_H
//   flashClk     out  flash phase, 1 blanks the glyph
//   dirH         out  0 = moving right, 1 = moving left
//   dirV         out  0 = moving down, 1 = moving up
//   bounce       out  one-cycle pulse after a commit that reversed a direction
//   stateDbg     out  [2:0] current motion FSM state
//
// Strobe protocol: frameTick and loadEn are single-cycle strobes with no
// back-pressure. A strobe is acted on in the cycle it is high or it is lost;
// nothing is queued. loadEn outranks frameTick when both arrive together.
// ---------------------------------------------------------------------------
module char_motion_ctrl #(
    parameter int H_LIMIT      = 320,
    parameter int V_LIMIT      = 240,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int MIN_POS      = 2,
    parameter int H_INIT       = 2,
    parameter int V_INIT       = 2,
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       enable,
    input  logic [3:0] speedH,
    input  logic [3:0] speedV,
    input  logic       loadEn,
    input  logic [8:0] loadH,
    input  logic [8:0] loadV,
    output logic [8:0] posHorStart,
    output logic [8:0] posHorEnd,
    output logic [8:0] posVerStart,
    output logic [8:0] posVerEnd,
    output logic       flashClk,
    output logic       dirH,
    output logic       dirV,
    output logic       bounce,
    output logic [2:0] stateDbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        STEP_H     = 3'd2,
        STEP_V     = 3'd3,
        COMMIT     = 3'd4
    } stateT;

    // Highest legal start position on each axis (start + size == limit).
    localparam logic [9:0] H_MAX   = 10'(H_LIMIT - CHAR_W);
    localparam logic [9:0] V_MAX   = 10'(V_LIMIT - CHAR_H);
    localparam logic [9:0] POS_MIN = 10'(MIN_POS);
    localparam logic [8:0] WIDTH9  = 9'(CHAR_W);
    localparam logic [8:0] HEIGHT9 = 9'(CHAR_H);
    localparam logic [8:0] H_RST   = 9'(H_INIT);
    localparam logic [8:0] V_RST   = 9'(V_INIT);

    // Reject parameter sets the 9-bit position datapath cannot represent.
    if (FLASH_FRAMES < 1 || H_LIMIT > 511 || V_LIMIT > 511 ||
        MIN_POS > H_LIMIT - CHAR_W || MIN_POS > V_LIMIT - CHAR_H) begin : gBadParams
        $error("char_motion_ctrl: parameter set out of range");
    end

    stateT      state;
    stateT      nextState;
    logic       doStepH;
    logic       doStepV;
    logic       doCommit;

    logic [8:0] curH;
    logic [8:0] curV;
    logic [8:0] nxtH;
    logic [8:0] nxtV;
    logic       nxtDirH;
    logic       nxtDirV;
    logic       bncH;
    logic       bncV;
    logic [8:0] clampH;
    logic [8:0] clampV;

    // One axis step. Returns {bounced, newDir, newPos}. Intermediates are
    // 10 bits wide so start + speed can never wrap.
    function automatic logic [10:0] stepAxis(
        input logic [8:0] cur,
        input logic [3:0] speed,
        input logic       dir,
        input logic [9:0] maxPos
    );
        logic [9:0] wide;
        logic [9:0] sum;
        logic [8:0] diff;
        wide = {1'b0, cur};
        sum  = wide + {6'd0, speed};
        diff = cur - {5'd0, speed};
        if (!dir) begin
            // sum + size > limit  <=>  sum > limit - size; landing on it is legal.
            if (sum > maxPos) begin
                return {1'b1, 1'b1, maxPos[8:0]};
            end
            return {1'b0, 1'b0, sum[8:0]};
        end
        if (wide < POS_MIN + {6'd0, speed}) begin
            return {1'b1, 1'b0, POS_MIN[8:0]};
        end
        return {1'b0, 1'b1, diff};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        nextState = state;
        if (loadEn) begin
            // A load aborts any step in flight and drops a coincident tick.
            nextState = enable ? WAIT_FRAME : IDLE;
        end else begin
            case (state)
                IDLE:       if (enable) nextState = WAIT_FRAME;
                WAIT_FRAME: begin
                    if (!enable) begin
                        nextState = IDLE;
                    end else if (frameTick) begin
                        nextState = STEP_H;
                    end
                end
                STEP_H:     nextState = STEP_V;
                STEP_V:     nextState = COMMIT;
                COMMIT:     nextState = enable ? WAIT_FRAME : IDLE;
                default:    nextState = IDLE;
            endcase
        end
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        doStepH  = 1'b0;
        doStepV  = 1'b0;
        doCommit = 1'b0;
        case (state)
            STEP_H:  doStepH  = 1'b1;
            STEP_V:  doStepV  = 1'b1;
            COMMIT:  doCommit = 1'b1;
            default: ;
        endcase
    end

    assign stateDbg = state;

    // ---------------- load clamping ----------------
    always_comb begin
        clampH = loadH;
        if ({1'b0, loadH} < POS_MIN) begin
            clampH = POS_MIN[8:0];
        end else if ({1'b0, loadH} > H_MAX) begin
            clampH = H_MAX[8:0];
        end
        clampV = loadV;
        if ({1'b0, loadV} < POS_MIN) begin
            clampV = POS_MIN[8:0];
        end else if ({1'b0, loadV} > V_MAX) begin
            clampV = V_MAX[8:0];
        end
    end

    // ---------------- position datapath ----------------
    // Steps are staged in nxt*/bnc* and only become visible on COMMIT, so all
    // four edges and both directions change in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            curH        <= H_RST;
            curV        <= V_RST;
            nxtH        <= H_RST;
            nxtV        <= V_RST;
            nxtDirH     <= 1'b0;
            nxtDirV     <= 1'b0;
            bncH        <= 1'b0;
            bncV        <= 1'b0;
            posHorStart <= H_RST;
            posHorEnd   <= H_RST + WIDTH9;
            posVerStart <= V_RST;
            posVerEnd   <= V_RST + HEIGHT9;
            dirH        <= 1'b0;
            dirV        <= 1'b0;
            bounce      <= 1'b0;
        end else if (loadEn) begin
            curH        <= clampH;
            curV        <= clampV;
            bncH        <= 1'b0;
            bncV        <= 1'b0;
            posHorStart <= clampH;
            posHorEnd   <= clampH + WIDTH9;
            posVerStart <= clampV;
            posVerEnd   <= clampV + HEIGHT9;
            bounce      <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (doStepH) begin
                {bncH, nxtDirH, nxtH} <= stepAxis(curH, speedH, dirH, H_MAX);
            end
            if (doStepV) begin
                {bncV, nxtDirV, nxtV} <= stepAxis(curV, speedV, dirV, V_MAX);
            end
            if (doCommit) begin
                curH        <= nxtH;
                curV        <= nxtV;
                posHorStart <= nxtH;
                posHorEnd   <= nxtH + WIDTH9;
                posVerStart <= nxtV;
                posVerEnd   <= nxtV + HEIGHT9;
                dirH        <= nxtDirH;
                dirV        <= nxtDirV;
                bounce      <= bncH | bncV;
            end
        end
    end

    // ---------------- flash phase ----------------
`ifdef CHAR_FLASH_EN
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    logic [FW-1:0] flashCnt;

    // Counts every frame tick regardless of enable, FSM state or loads.
    always_ff @(posedge clock) begin
        if (reset) begin
            flashCnt <= '0;
            flashClk <= 1'b0;
        end else if (frameTick) begin
            if (flashCnt == FLASH_LAST) begin
                flashCnt <= '0;
                flashClk <= ~flashClk;
            end else begin
                flashCnt <= flashCnt + FW'(1);
            end
        end
    end
`else
    // Without the flash feature the glyph is never blanked.
    assign flashClk = 1'b0;
`endif

endmodule
